// File: rtl/hartslag_meter.sv
// hartslag_meter: heart-rate meter with prescaler, refractory window,
// 2^AVG_LOG-beat period averaging, iterative BPM divider and loss detection.
module hartslag_meter #(
    parameter int OUT_W         = 8,
    parameter int CNT_W         = 16,
    parameter int AVG_LOG       = 2,
    parameter int TICKS_PER_MIN = 6000,
    parameter int REFRACT       = 25,
    parameter int TIMEOUT       = 300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       ClockSnelheid,
    input  logic             hartslagIngang,
    output logic [OUT_W-1:0] hartslag,
    output logic             hartslag_valid,
    output logic             beat,
    output logic             geen_hartslag
);
    localparam int DIV_W = $clog2(TICKS_PER_MIN + 1);
    localparam int DEPTH = 1 << AVG_LOG;
    localparam int SUM_W = CNT_W + AVG_LOG;
    localparam int CW    = $clog2(DIV_W + 1);
    localparam int QW    = DIV_W > OUT_W ? DIV_W : OUT_W;
    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(TICKS_PER_MIN);
    localparam logic [QW-1:0]    QMAX     = QW'((1 << OUT_W) - 1);
    localparam logic [CNT_W-1:0] TO       = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] RF       = CNT_W'(REFRACT);

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q, s3_q, edge_q;
    logic [7:0]         pc_q, pc_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d, sample_q, sample_d;
    logic               push_q, push_d, pend_q, pend_d, to_q, to_d, first_q, first_d;
    logic [CNT_W-1:0]   win_q [DEPTH];
    logic [CNT_W-1:0]   win_d [DEPTH];
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   div_q, div_d, rem_q, rem_d;
    logic [DIV_W-1:0]   num_q, num_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [OUT_W-1:0]   hartslag_q, hartslag_d;
    logic               valid_q, valid_d, beat_q, beat_d, geen_q, geen_d;
    logic               tick, to_hit, accept, ge, sat, last, start, give_up;
    logic [CNT_W-1:0]   pcnt_inc, avg;
    logic [CNT_W:0]     rem_sh;
    logic [DIV_W-1:0]   q_fin;

    // Two-flop synchroniser, then a registered rising-edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {s1_q, s2_q, s3_q, edge_q} <= '0;
        end else begin
            s1_q   <= hartslagIngang;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            edge_q <= s2_q & ~s3_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            pcnt_q     <= '0;
            sample_q   <= '0;
            push_q     <= 1'b0;
            pend_q     <= 1'b0;
            to_q       <= 1'b0;
            first_q    <= 1'b1;
            win_q      <= '{default: '0};
            sum_q      <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            num_q      <= '0;
            cnt_q      <= '0;
            hartslag_q <= '0;
            valid_q    <= 1'b0;
            beat_q     <= 1'b0;
            geen_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pcnt_q     <= pcnt_d;
            sample_q   <= sample_d;
            push_q     <= push_d;
            pend_q     <= pend_d;
            to_q       <= to_d;
            first_q    <= first_d;
            win_q      <= win_d;
            sum_q      <= sum_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            hartslag_q <= hartslag_d;
            valid_q    <= valid_d;
            beat_q     <= beat_d;
            geen_q     <= geen_d;
        end
    end

    always_comb begin
        tick       = pc_q >= ClockSnelheid;
        pc_d       = tick ? 8'd0 : pc_q + 8'd1;
        // The tick landing on the accepting clock still belongs to the closing period.
        pcnt_inc   = (tick && pcnt_q != '1) ? pcnt_q + CNT_W'(1) : pcnt_q;
        to_hit     = pcnt_q >= TO;
        accept     = edge_q && (state_q == IDLE || pcnt_inc >= RF) && !(state_q == MEASURE && to_hit);
        avg        = CNT_W'(sum_q >> AVG_LOG);
        rem_sh     = {rem_q, num_q[DIV_W-1]};
        ge         = rem_sh >= {1'b0, div_q};
        q_fin      = {num_q[DIV_W-2:0], ge};
        sat        = div_q == '0 || QW'(q_fin) > QMAX;
        last       = cnt_q == CW'(DIV_W - 1);
        start      = 1'b0;
        give_up    = 1'b0;
        state_d    = state_q;
        pcnt_d     = accept ? '0 : pcnt_inc;
        sample_d   = accept ? pcnt_inc : sample_q;
        push_d     = accept && state_q != IDLE;
        beat_d     = accept;
        pend_d     = pend_q;
        to_d       = to_q || (state_q == DIVIDE && to_hit);
        first_d    = first_q;
        win_d      = win_q;
        sum_d      = sum_q;
        div_d      = div_q;
        rem_d      = rem_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        hartslag_d = hartslag_q;
        valid_d    = 1'b0;
        geen_d     = geen_q;
        if (push_q) begin
            for (int i = DEPTH - 1; i > 0; i--) win_d[i] = first_q ? sample_q : win_q[i-1];
            win_d[0] = sample_q;
            sum_d    = first_q ? SUM_W'(sample_q) << AVG_LOG
                               : sum_q + SUM_W'(sample_q) - SUM_W'(win_q[DEPTH-1]);
            first_d  = 1'b0;
            pend_d   = 1'b1;
        end
        if (state_q == IDLE) begin
            state_d = accept ? MEASURE : IDLE;
        end else if (state_q == MEASURE) begin
            give_up = to_hit;
            start   = !to_hit && pend_q;
        end else begin
            rem_d = ge ? CNT_W'(rem_sh - {1'b0, div_q}) : rem_sh[CNT_W-1:0];
            num_d = q_fin;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                hartslag_d = sat ? OUT_W'(QMAX) : OUT_W'(q_fin);
                valid_d    = 1'b1;
                geen_d     = 1'b0;
                state_d    = MEASURE;
                give_up    = to_q || to_hit;
                start      = !(to_q || to_hit) && pend_q;
            end
        end
        if (start) begin
            state_d = DIVIDE;
            div_d   = avg;
            rem_d   = '0;
            num_d   = DIVIDEND;
            cnt_d   = '0;
            pend_d  = push_q;
        end
        // Loss of heartbeat outranks any result or pending division.
        if (give_up) begin
            state_d    = IDLE;
            hartslag_d = '0;
            valid_d    = 1'b1;
            geen_d     = 1'b1;
            win_d      = '{default: '0};
            sum_d      = '0;
            first_d    = 1'b1;
            pend_d     = 1'b0;
            to_d       = 1'b0;
        end
    end

    assign hartslag       = hartslag_q;
    assign hartslag_valid = valid_q;
    assign beat           = beat_q;
    assign geen_hartslag  = geen_q;
endmodule
